vga_rx: RTL and testbench

VGA_RX -- requirements
Module: vga_rx

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_edge_det.sv | 20 ++
 rtl/vga_rx.sv | 108 ++++++++++
 tb/tb_vga_rx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, line/frame total helpers and receiver FSM states
package vga_pkg;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FP_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FP_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF = 33;
  localparam bit SYNC_POL_DEF = 1'b0;
  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;
  function automatic int h_total(int vis, int fp, int sync, int bp);
    return vis + fp + sync + bp;
  endfunction
  function automatic int v_total(int vis, int fp, int sync, int bp);
    return vis + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_edge_det.sv
// vga_edge_det: registers one sync line (px_clk, rst_n, sync in; pulse out) and pulses on its asserting edge
module vga_edge_det import vga_pkg::*; #(
  parameter bit SYNC_POL = SYNC_POL_DEF
) (
  input logic px_clk,
  input logic rst_n,
  input logic sync,
  output logic pulse
);
  logic cur, prev;
  always_ff @(posedge px_clk or negedge rst_n)
    if (!rst_n) begin
      cur <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur <= sync == SYNC_POL;
      prev <= cur;
    end
  assign pulse = cur && !prev;
endmodule

// File: rtl/vga_rx.sv
// vga_rx: recovers lock, pixel coordinates and valid pixels from a VGA hsync/vsync/rgb stream; VGA_RX_CHECKSUM_EN adds frame_sum/sum_valid
module vga_rx import vga_pkg::*; #(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  parameter bit SYNC_POL = SYNC_POL_DEF
) (
  input logic px_clk,
  input logic rst_n,
  input logic hsync,
  input logic vsync,
  input logic [2:0] rgb,
  output logic [9:0] x_px,
  output logic [9:0] y_px,
  output logic [2:0] px_rgb,
  output logic px_valid,
  output logic frame_start,
  output logic locked,
  output logic err
`ifdef VGA_RX_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum,
  output logic sum_valid
`endif
);
  localparam logic [9:0] H_MAX = 10'(h_total(H_VISIBLE, H_FP, H_SYNC, H_BP));
  localparam logic [9:0] H_LAST = 10'(h_total(H_VISIBLE, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [9:0] V_LAST = 10'(v_total(V_VISIBLE, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [9:0] H_ON = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_OFF = 10'(H_SYNC + H_BP + H_VISIBLE - 1);
  localparam logic [9:0] V_ON = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_OFF = 10'(V_SYNC + V_BP + V_VISIBLE - 1);
  state_t state, state_nx;
  logic h_edge, v_edge, v_pend, v_reset, bad, over, active, valid, err_nx;
  logic [9:0] hcount, vcount, h_cur, v_cur;
  logic [2:0] rgb1;
  vga_edge_det #(.SYNC_POL(SYNC_POL)) u_hsync (.px_clk(px_clk), .rst_n(rst_n), .sync(hsync), .pulse(h_edge));
  vga_edge_det #(.SYNC_POL(SYNC_POL)) u_vsync (.px_clk(px_clk), .rst_n(rst_n), .sync(vsync), .pulse(v_edge));
  always_comb begin
    v_reset = h_edge && (v_pend || v_edge);
    h_cur = h_edge ? '0 : hcount == H_MAX ? H_MAX : hcount + 10'd1;
    v_cur = v_reset ? '0 : h_edge ? vcount + 10'd1 : vcount;
    bad = h_edge && (hcount != H_LAST || (v_reset && vcount != V_LAST));
    over = !h_edge && h_cur == H_MAX;
    active = h_cur >= H_ON && h_cur <= H_OFF && v_cur >= V_ON && v_cur <= V_OFF;
  end
  always_ff @(posedge px_clk or negedge rst_n)
    if (!rst_n) state <= HUNT;
    else state <= state_nx;
  always_comb
    state_nx = state == HUNT ? (v_edge ? ALIGN : HUNT)
             : bad || (state == LOCKED && over) ? HUNT
             : state == ALIGN && v_reset ? LOCKED : state;
  always_comb begin
    locked = state == LOCKED;
    err_nx = locked && (bad || over);
    valid = locked && active;
  end
  always_ff @(posedge px_clk or negedge rst_n)
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
      v_pend <= 1'b0;
      rgb1 <= '0;
      err <= 1'b0;
      px_valid <= 1'b0;
      px_rgb <= '0;
      x_px <= '0;
      y_px <= '0;
      frame_start <= 1'b0;
    end else begin
      hcount <= h_cur;
      vcount <= v_cur;
      v_pend <= !h_edge && (v_pend || v_edge);
      rgb1 <= rgb;
      err <= err_nx;
      px_valid <= valid;
      px_rgb <= valid ? rgb1 : '0;
      x_px <= valid ? h_cur - H_ON : '0;
      y_px <= valid ? v_cur - V_ON : '0;
      frame_start <= valid && h_cur == H_ON && v_cur == V_ON;
    end
`ifdef VGA_RX_CHECKSUM_EN
  localparam logic [9:0] X_LAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_VISIBLE - 1);
  logic [15:0] acc, acc_nx;
  logic last;
  always_comb begin
    acc_nx = (frame_start ? 16'd0 : acc) + 16'(px_rgb);
    last = px_valid && x_px == X_LAST && y_px == Y_LAST;
  end
  always_ff @(posedge px_clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      frame_sum <= '0;
      sum_valid <= 1'b0;
    end else begin
      if (px_valid) acc <= acc_nx;
      if (last) frame_sum <= acc_nx;
      sum_valid <= last;
    end
`endif
endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: randomized scoreboard bench for vga_rx on a reduced timing grid
module tb_vga_rx;
  localparam int HV = 16, HF = 2, HS = 3, HB = 3;
  localparam int VV = 8, VF = 1, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB, VT = VV + VF + VS + VB;
  localparam int HA = HS + HB, VA = VS + VB, NF = 11;
  localparam bit SP = 1'b0;
  typedef struct { int cyc; int x; int y; int rgb; int fs; } pix_t;
  typedef struct { int cyc; int lk; int er; } st_t;
  typedef struct { int cyc; int sum; } sum_t;
  logic px_clk = 1'b0, rst_n = 1'b0, hsync = ~SP, vsync = ~SP;
  logic [2:0] rgb = '0;
  logic [9:0] x_px, y_px;
  logic [2:0] px_rgb;
  logic px_valid, frame_start, locked, err;
`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] frame_sum;
  logic sum_valid;
  sum_t sm;
`endif
  pix_t pix_q[$];
  st_t st_q[$];
  sum_t sum_q[$];
  pix_t pp;
  st_t ss;
  int cyc = 0, n_chk = 0, n_fail = 0;
  vga_rx #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(SP)
  ) dut (
    .px_clk(px_clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .x_px(x_px), .y_px(y_px), .px_rgb(px_rgb), .px_valid(px_valid),
    .frame_start(frame_start), .locked(locked), .err(err)
`ifdef VGA_RX_CHECKSUM_EN
    , .frame_sum(frame_sum), .sum_valid(sum_valid)
`endif
  );
  always #5 px_clk = ~px_clk;
  always @(posedge px_clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask
  task automatic check_zero(input string name);
    check(name, int'({x_px, y_px, px_rgb, px_valid, frame_start, locked, err}), 0);
`ifdef VGA_RX_CHECKSUM_EN
    check({name, "_sum"}, int'({frame_sum, sum_valid}), 0);
`endif
  endtask
  always @(negedge px_clk) begin
    while (st_q.size() > 0 && st_q[0].cyc < cyc) void'(st_q.pop_front());
    if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
      ss = st_q.pop_front();
      check("locked", int'(locked), ss.lk);
      check("err", int'(err), ss.er);
    end
    if (px_valid) begin
      if (pix_q.size() == 0) fail("unexpected_px_valid");
      else begin
        pp = pix_q.pop_front();
        check("px_latency", cyc, pp.cyc);
        check("x_px", int'(x_px), pp.x);
        check("y_px", int'(y_px), pp.y);
        check("px_rgb", int'(px_rgb), pp.rgb);
        check("frame_start", int'(frame_start), pp.fs);
      end
    end else begin
      check("idle_rgb_fs", int'({px_rgb, frame_start}), 0);
      if (pix_q.size() > 0 && pix_q[0].cyc <= cyc) begin
        fail("missing_px_valid");
        void'(pix_q.pop_front());
      end
    end
`ifdef VGA_RX_CHECKSUM_EN
    if (sum_valid) begin
      if (sum_q.size() == 0) fail("unexpected_sum_valid");
      else begin
        sm = sum_q.pop_front();
        check("sum_latency", cyc, sm.cyc);
        check("frame_sum", int'(frame_sum), sm.sum);
      end
    end else if (sum_q.size() > 0 && sum_q[0].cyc <= cyc) begin
      fail("missing_sum_valid");
      void'(sum_q.pop_front());
    end
`endif
  end
  initial begin
    #1000000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    int short_l, rst_l, rst_p, starts, lk, er, sum, len;
    logic [2:0] c;
    repeat (3) @(negedge px_clk);
    check_zero("reset_outputs");
    rst_n = 1'b1;
    starts = 0;
    sum = 0;
    for (int f = 0; f < NF; f++) begin
      short_l = f == 3 ? int'($urandom_range(VT - 2, 0)) : -1;
      rst_l = f == 7 ? int'($urandom_range(VT - 2, VS)) : -1;
      rst_p = int'($urandom_range(HT - 2, HS + 1));
      for (int l = 0; l < VT; l++) begin
        len = l == short_l ? HT - 1 : HT;
        for (int p = 0; p < len; p++) begin
          @(negedge px_clk);
          rst_n = 1'b1;
          c = f == 6 || (f == 2 && l == VA + 7 && p == HA + 5) ? 3'd7 : 3'($urandom_range(7, 0));
          hsync = p < HS ? SP : ~SP;
          vsync = l < VS ? SP : ~SP;
          rgb = c;
          er = 0;
          if (l == rst_l && p == rst_p) begin
            #2 rst_n = 1'b0;
            #1 check_zero("async_reset");
            pix_q.delete();
            st_q.delete();
            sum_q.delete();
            starts = 0;
          end else if (p == 0 && l == 0) starts = starts == 2 ? 2 : starts + 1;
          else if (p == 0 && l == short_l + 1) begin
            er = int'(starts == 2);
            starts = 0;
          end
          lk = int'(starts == 2);
          st_q.push_back('{cyc + 2, lk, er});
          if (lk == 1 && p >= HA && p < HA + HV && l >= VA && l < VA + VV) begin
            pix_q.push_back('{cyc + 2, p - HA, l - VA, int'(c), int'(p == HA && l == VA)});
            sum = (((p == HA && l == VA) ? 0 : sum) + int'(c)) % 65536;
            if (p == HA + HV - 1 && l == VA + VV - 1) sum_q.push_back('{cyc + 3, sum});
          end
        end
      end
    end
    repeat (3) @(negedge px_clk);
    check("pixels_left", pix_q.size(), 0);
`ifdef VGA_RX_CHECKSUM_EN
    check("sums_left", sum_q.size(), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
